ir_key_ctrl: RTL and testbench

Key-event scheduler between the NEC infrared receiver and the application logic (display, LED and buzzer control). It turns decoded frames (frame_vld pulse plus key code) and repeat-code indications (repeat_en) into PRESS, REPEAT and RELEASE events. Events are buffered in a small FIFO and delivered over a valid/ready interface. It owns hold tracking, auto-repeat pacing and release timeout.

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_evt_fifo.sv | 57 +++++
 rtl/ir_key_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ir_key_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC infrared key path: widths, event codes,
// controller state encoding and the 50 MHz NEC timing constants.
package ir_pkg;

  localparam int KEY_W = 8;
  localparam int EVT_W = 2;

  localparam logic [EVT_W-1:0] EVT_PRESS   = EVT_W'(1);
  localparam logic [EVT_W-1:0] EVT_REPEAT  = EVT_W'(2);
  localparam logic [EVT_W-1:0] EVT_RELEASE = EVT_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  // NEC protocol timing in 20 ns system clock cycles.
  localparam int NEC_LEAD_HI_CYC  = 450_000;
  localparam int NEC_LEAD_LO_CYC  = 225_000;
  localparam int NEC_REP_LO_CYC   = 112_500;
  localparam int NEC_BIT_CYC      = 28_000;
  localparam int NEC_ONE_LO_CYC   = 84_500;
  localparam int NEC_FRAME_CYC    = 5_400_000;

endpackage

// File: rtl/ir_evt_fifo.sv
// Small event FIFO built as a shift register so the head entry is always a
// flop; unused slots are kept at zero, so an empty FIFO presents zero data.
module ir_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_idx;
  logic             do_pop, do_push;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[0];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign wr_idx  = do_pop ? (cnt_q[AW-1:0] - AW'(1)) : cnt_q[AW-1:0];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      cnt_d = cnt_q - CW'(1);
    end
    if (do_push) begin
      mem_d[wr_idx] = push_data_i;
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// Key-event scheduler: turns decoded NEC frames and repeat codes into
// PRESS / REPEAT / RELEASE events queued for the application logic.
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter int RELEASE_CNT = 6_000_000,
  parameter int REPEAT_DLY  = 4,
  parameter int REPEAT_DIV  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             frame_vld,
  input  logic [KEY_W-1:0] key_code,
  input  logic             repeat_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_type,
  output logic [KEY_W-1:0] evt_code,
  output logic             key_held,
  output logic [KEY_W-1:0] held_code,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int RW = $clog2(RELEASE_CNT);
  localparam int PW = $clog2(REPEAT_DLY + 1);
  localparam int DW = $clog2(REPEAT_DIV + 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CNT - 1);
  localparam logic [PW-1:0] DLY_V    = PW'(REPEAT_DLY);
  localparam logic [DW-1:0] DIV_V    = DW'(REPEAT_DIV);

  state_t                   state_q, state_d;
  logic [RW-1:0]            rel_cnt_q, rel_cnt_d;
  logic [PW-1:0]            rep_cnt_q, rep_cnt_d;
  logic [DW-1:0]            div_cnt_q, div_cnt_d;
  logic [KEY_W-1:0]         held_q, held_d;
  logic [KEY_W-1:0]         pend_q, pend_d;
  logic                     key_held_q;
  logic                     rep_prev_q;
  logic                     ovf_q, ovf_d;
  logic                     rep_edge;
  logic                     push, pop, full, empty, drop;
  logic [EVT_W+KEY_W-1:0]   push_data, head;

  assign rep_edge = repeat_en & ~rep_prev_q;
  assign pop      = evt_valid & evt_ready;
  assign drop     = push & full & ~pop;

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    rep_cnt_d = rep_cnt_q;
    div_cnt_d = div_cnt_q;
    held_d    = held_q;
    pend_d    = pend_q;
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_vld) begin
          push      = 1'b1;
          push_data = {EVT_PRESS, key_code};
          held_d    = key_code;
          rel_cnt_d = '0;
          rep_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = ST_HELD;
        end
      end
      ST_HELD: begin
        // A new frame beats both the repeat edge and the timeout.
        if (frame_vld) begin
          push      = 1'b1;
          push_data = {EVT_RELEASE, held_q};
          pend_d    = key_code;
          state_d   = ST_SWAP;
        end else if (rep_edge) begin
          rel_cnt_d = '0;
          if (rep_cnt_q != DLY_V) begin
            rep_cnt_d = rep_cnt_q + PW'(1);
            if (rep_cnt_d == DLY_V) begin
              push      = 1'b1;
              push_data = {EVT_REPEAT, held_q};
              div_cnt_d = '0;
            end
          end else if (div_cnt_q + DW'(1) == DIV_V) begin
            push      = 1'b1;
            push_data = {EVT_REPEAT, held_q};
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end else if (rel_cnt_q == REL_LAST) begin
          push      = 1'b1;
          push_data = {EVT_RELEASE, held_q};
          state_d   = ST_IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + RW'(1);
        end
      end
      ST_SWAP: begin
        push      = 1'b1;
        push_data = {EVT_PRESS, pend_q};
        held_d    = pend_q;
        rel_cnt_d = '0;
        rep_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = ST_HELD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      rel_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      div_cnt_q  <= '0;
      held_q     <= '0;
      pend_q     <= '0;
      key_held_q <= 1'b0;
      rep_prev_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rel_cnt_q  <= rel_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      div_cnt_q  <= div_cnt_d;
      held_q     <= held_d;
      pend_q     <= pend_d;
      key_held_q <= (state_d != ST_IDLE);
      rep_prev_q <= repeat_en;
      ovf_q      <= ovf_d;
    end
  end

  ir_evt_fifo #(
    .WIDTH (EVT_W + KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .push_i      (push),
    .push_data_i (push_data),
    .full_o      (full),
    .pop_i       (pop),
    .empty_o     (empty),
    .head_o      (head)
  );

  assign evt_valid = ~empty;
  assign evt_type  = head[KEY_W +: EVT_W];
  assign evt_code  = head[KEY_W-1:0];
  assign key_held  = key_held_q;
  assign held_code = held_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl with short timeouts; every popped event is
// logged on the falling edge and compared against hand-built lists.
module tb_ir_key_ctrl;

  logic       sysClk = 1'b0;
  logic       sysRst;
  logic       frameVld;
  logic [7:0] keyCode;
  logic       repeatEn;
  logic       evtValid;
  logic       evtReady;
  logic [1:0] evtType;
  logic [7:0] evtCode;
  logic       keyHeld;
  logic [7:0] heldCode;
  logic       ovf;
  logic       ovfClr;

  int         checkCount = 0;
  int         passCount  = 0;
  logic [9:0] evtLog [$];
  logic [9:0] expLog [$];

  ir_key_ctrl #(
    .RELEASE_CNT (1000),
    .REPEAT_DLY  (2),
    .REPEAT_DIV  (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .sys_clk   (sysClk),
    .sys_rst   (sysRst),
    .frame_vld (frameVld),
    .key_code  (keyCode),
    .repeat_en (repeatEn),
    .evt_valid (evtValid),
    .evt_ready (evtReady),
    .evt_type  (evtType),
    .evt_code  (evtCode),
    .key_held  (keyHeld),
    .held_code (heldCode),
    .ovf       (ovf),
    .ovf_clr   (ovfClr)
  );

  always #5 sysClk = ~sysClk;

  always @(negedge sysClk) begin
    if (evtValid && evtReady) evtLog.push_back({evtType, evtCode});
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] ev(input logic [1:0] t, input logic [7:0] c);
    return {t, c};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // One cycle with the given frame/repeat levels, then frame low for the rest.
  task automatic applyStimulus(input logic frameV, input logic [7:0] code,
                               input logic repV, input int cycles);
    frameVld = frameV;
    keyCode  = code;
    repeatEn = repV;
    tick();
    frameVld = 1'b0;
    for (int i = 1; i < cycles; i++) tick();
  endtask

  task automatic checkLog(input string tag);
    checkOutput($sformatf("%s_len", tag), evtLog.size(), expLog.size());
    for (int i = 0; i < expLog.size(); i++)
      checkOutput($sformatf("%s_ev%0d", tag, i),
                  (i < evtLog.size()) ? evtLog[i] : 10'h3ff, expLog[i]);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (keyHeld && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, keyHeld, 0);
  endtask

  initial begin
    int n;
    sysRst   = 1'b1;
    frameVld = 1'b0;
    keyCode  = 8'h00;
    repeatEn = 1'b0;
    evtReady = 1'b0;
    ovfClr   = 1'b0;
    repeat (3) tick();
    sysRst = 1'b0;
    checkOutput("rst_valid", evtValid, 0);
    checkOutput("rst_type", evtType, 0);
    checkOutput("rst_code", evtCode, 0);
    checkOutput("rst_held", keyHeld, 0);
    checkOutput("rst_heldcode", heldCode, 0);
    checkOutput("rst_ovf", ovf, 0);

    // Test 1: press and exact release timeout
    evtReady = 1'b1;
    evtLog.delete();
    applyStimulus(1'b1, 8'h45, 1'b0, 1);
    checkOutput("t1_valid", evtValid, 1);
    checkOutput("t1_type", evtType, 1);
    checkOutput("t1_code", evtCode, 8'h45);
    checkOutput("t1_held", keyHeld, 1);
    checkOutput("t1_heldcode", heldCode, 8'h45);
    n = 0;
    do begin
      tick();
      n++;
    end while (!evtValid && n < 1100);
    checkOutput("t1_rel_latency", n, 1000);
    checkOutput("t1_rel_type", evtType, 3);
    checkOutput("t1_rel_code", evtCode, 8'h45);
    checkOutput("t1_rel_held", keyHeld, 0);
    tick();
    expLog = '{ev(2'd1, 8'h45), ev(2'd3, 8'h45)};
    checkLog("t1");

    // Test 2: auto-repeat pacing
    evtLog.delete();
    applyStimulus(1'b1, 8'h16, 1'b0, 1);
    for (int p = 0; p < 7; p++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 50);
      applyStimulus(1'b0, 8'h00, 1'b0, 450);
    end
    checkOutput("t2_still_held", keyHeld, 1);
    waitIdle("t2_idle", 1200);
    repeat (2) tick();
    expLog = '{ev(2'd1, 8'h16), ev(2'd2, 8'h16), ev(2'd2, 8'h16),
               ev(2'd2, 8'h16), ev(2'd3, 8'h16)};
    checkLog("t2");

    // Test 3: key swap, repeat edge in the swap cycle is ignored
    evtLog.delete();
    applyStimulus(1'b1, 8'h0C, 1'b0, 5);
    applyStimulus(1'b1, 8'h18, 1'b0, 1);
    checkOutput("t3_rel_type", evtType, 3);
    checkOutput("t3_rel_code", evtCode, 8'h0C);
    applyStimulus(1'b0, 8'h00, 1'b1, 1);
    checkOutput("t3_press_type", evtType, 1);
    checkOutput("t3_press_code", evtCode, 8'h18);
    checkOutput("t3_heldcode", heldCode, 8'h18);
    applyStimulus(1'b0, 8'h00, 1'b1, 10);
    applyStimulus(1'b0, 8'h00, 1'b0, 20);
    applyStimulus(1'b0, 8'h00, 1'b1, 5);
    applyStimulus(1'b0, 8'h00, 1'b0, 50);
    expLog = '{ev(2'd1, 8'h0C), ev(2'd3, 8'h0C), ev(2'd1, 8'h18)};
    checkLog("t3a");
    waitIdle("t3_idle", 1200);
    repeat (2) tick();
    expLog.push_back(ev(2'd3, 8'h18));
    checkLog("t3b");

    // Test 5: orphan repeat codes while idle
    evtLog.delete();
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 10);
      applyStimulus(1'b0, 8'h00, 1'b0, 10);
    end
    checkOutput("t5_held", keyHeld, 0);
    checkOutput("t5_valid", evtValid, 0);
    expLog.delete();
    checkLog("t5");

    // Test 4: overflow with a stalled consumer
    evtReady = 1'b0;
    evtLog.delete();
    applyStimulus(1'b1, 8'h01, 1'b0, 4);
    applyStimulus(1'b1, 8'h02, 1'b0, 4);
    checkOutput("t4_ovf_pre", ovf, 0);
    applyStimulus(1'b1, 8'h03, 1'b0, 4);
    applyStimulus(1'b0, 8'h00, 1'b1, 5);
    applyStimulus(1'b0, 8'h00, 1'b0, 5);
    applyStimulus(1'b0, 8'h00, 1'b1, 5);
    applyStimulus(1'b0, 8'h00, 1'b0, 5);
    checkOutput("t4_ovf", ovf, 1);
    checkOutput("t4_head_valid", evtValid, 1);
    checkOutput("t4_head_type", evtType, 1);
    checkOutput("t4_head_code", evtCode, 8'h01);
    ovfClr = 1'b1;
    tick();
    ovfClr = 1'b0;
    checkOutput("t4_ovf_clr", ovf, 0);
    evtReady = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 6);
    expLog = '{ev(2'd1, 8'h01), ev(2'd3, 8'h01), ev(2'd1, 8'h02), ev(2'd3, 8'h02)};
    checkLog("t4");
    checkOutput("t4_drained", evtValid, 0);

    // Test 6: reset while held with events queued
    evtReady = 1'b0;
    applyStimulus(1'b1, 8'h04, 1'b0, 4);
    checkOutput("t6_pre_valid", evtValid, 1);
    checkOutput("t6_pre_held", keyHeld, 1);
    sysRst = 1'b1;
    tick();
    sysRst = 1'b0;
    checkOutput("t6_valid", evtValid, 0);
    checkOutput("t6_held", keyHeld, 0);
    checkOutput("t6_ovf", ovf, 0);
    checkOutput("t6_heldcode", heldCode, 0);
    checkOutput("t6_type", evtType, 0);
    evtReady = 1'b1;
    evtLog.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 10);
    applyStimulus(1'b0, 8'h00, 1'b0, 20);
    checkOutput("t6_post_held", keyHeld, 0);
    expLog.delete();
    checkLog("t6");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
